counter_sched: RTL and testbench

Synchronous scheduler that shares one WIDTH-bit up-counter between two requesters. Each requester asks for a count of `len` ticks. The block arbitrates round-robin, loads and runs the counter for the winner, and returns a one-cycle completion pulse. It sits between the control logic and the counter datapath, replacing free-running ripple counting with sequenced, owned count windows.

---
 rtl/counter_sched_if.sv | 26 ++
 rtl/counter_sched.sv | 102 ++++++++++
 tb/tb_counter_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/counter_sched_if.sv
// rtl/counter_sched_if.sv - request/grant/count bundle between two requesters and counter_sched
interface counter_sched_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic             tick;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done0;
  logic             done1;

  modport master (
    output req0, req1, len0, len1, tick,
    input  gnt0, gnt1, q, busy, done0, done1
  );

  modport slave (
    input  req0, req1, len0, len1, tick,
    output gnt0, gnt1, q, busy, done0, done1
  );
endinterface

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin owner of a shared up-counter; COUNTER_SCHED_ABORT_EN enables owner abort
module counter_sched #(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            reset,
  counter_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef COUNTER_SCHED_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  state_t           state, state_nx;
  logic [WIDTH-1:0] q, q_nx;
  logic [WIDTH-1:0] len_lat, len_nx;
  logic             owner, owner_nx;
  logic             last, last_nx;
  logic             gnt0, gnt0_nx, gnt1, gnt1_nx;
  logic             done0, done0_nx, done1, done1_nx;
  logic             busy, busy_nx;
  logic             owner_req;

  assign owner_req = owner ? bus.req1 : bus.req0;

  always_comb begin
    state_nx = state;
    q_nx     = q;
    len_nx   = len_lat;
    owner_nx = owner;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // on a tie the requester not served last wins
          owner_nx = (bus.req0 && bus.req1) ? ~last : bus.req1;
          len_nx   = owner_nx ? bus.len1 : bus.len0;
          q_nx     = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (ABORT && !owner_req) begin
          state_nx = IDLE;
          last_nx  = owner;
        end else if (q == len_lat) begin
          state_nx = DONE;
        end else if (bus.tick) begin
          q_nx = q + WIDTH'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        last_nx  = owner;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx  = (state_nx != IDLE);
    gnt0_nx  = busy_nx && !owner_nx;
    gnt1_nx  = busy_nx && owner_nx;
    done0_nx = (state == RUN) && (state_nx == DONE) && !owner;
    done1_nx = (state == RUN) && (state_nx == DONE) && owner;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      q       <= '0;
      len_lat <= '0;
      owner   <= 1'b0;
      last    <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      q       <= q_nx;
      len_lat <= len_nx;
      owner   <= owner_nx;
      last    <= last_nx;
      gnt0    <= gnt0_nx;
      gnt1    <= gnt1_nx;
      done0   <= done0_nx;
      done1   <= done1_nx;
      busy    <= busy_nx;
    end
  end

  assign bus.gnt0  = gnt0;
  assign bus.gnt1  = gnt1;
  assign bus.q     = q;
  assign bus.busy  = busy;
  assign bus.done0 = done0;
  assign bus.done1 = done1;

endmodule

// File: tb/tb_counter_sched.sv
// tb/tb_counter_sched.sv - randomized check of counter_sched against a per-window reference model
module tb_counter_sched;

`ifdef COUNTER_SCHED_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  counter_sched_if #(.WIDTH(4)) bus ();

  counter_sched #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference: an ownership window with a tick count capped at the length
  int own = -1;
  int need = 0;
  int cnt = 0;
  bit fin = 1'b0;
  int last = 1;
  bit e_done0 = 1'b0;
  bit e_done1 = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = -1; need = 0; cnt = 0; fin = 1'b0; last = 1;
    e_done0 = 1'b0; e_done1 = 1'b0;
  endtask

  task automatic model_step();
    bit r0, r1;
    r0 = bus.req0;
    r1 = bus.req1;
    e_done0 = 1'b0;
    e_done1 = 1'b0;
    if (own < 0) begin
      if (r0 || r1) begin
        own  = (r0 && r1) ? 1 - last : (r0 ? 0 : 1);
        need = (own == 1) ? int'(bus.len1) : int'(bus.len0);
        cnt  = 0;
        fin  = 1'b0;
      end
    end else if (fin) begin
      last = own; own = -1; fin = 1'b0;
    end else if (ABORT && !((own == 1) ? r1 : r0)) begin
      last = own; own = -1;
    end else if (cnt == need) begin
      fin = 1'b1;
      if (own == 1) e_done1 = 1'b1; else e_done0 = 1'b1;
    end else if (bus.tick) begin
      cnt++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("gnt0", int'(bus.gnt0), int'(own == 0));
    chk("gnt1", int'(bus.gnt1), int'(own == 1));
    chk("q", int'(bus.q), cnt);
    chk("busy", int'(bus.busy), int'(own >= 0));
    chk("done0", int'(bus.done0), int'(e_done0));
    chk("done1", int'(bus.done1), int'(e_done1));
  endtask

  bit did_reset = 1'b0;

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.len0 = '0;   bus.len1 = '0;
    bus.tick = 1'b0;
    model_reset();
    #12;
    chk("rst_q", int'(bus.q), 0);
    chk("rst_gnt", int'({bus.gnt1, bus.gnt0}), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'({bus.done1, bus.done0}), 0);
    reset = 1'b1;

    // single request, len 3, tick held
    bus.req0 = 1'b1; bus.len0 = 4'd3; bus.tick = 1'b1;
    cyc(); chk("d1_gnt0", int'(bus.gnt0), 1); chk("d1_q0", int'(bus.q), 0);
    cyc(); chk("d1_q1", int'(bus.q), 1);
    bus.len0 = 4'd9;
    cyc(); chk("d1_q2", int'(bus.q), 2);
    cyc(); chk("d1_q3", int'(bus.q), 3); chk("d1_nodone", int'(bus.done0), 0);
    cyc(); chk("d1_done0", int'(bus.done0), 1); chk("d1_gnt_hold", int'(bus.gnt0), 1);
    bus.req0 = 1'b0;
    cyc(); chk("d1_done_off", int'(bus.done0), 0); chk("d1_gnt_off", int'(bus.gnt0), 0);
    chk("d1_q_hold", int'(bus.q), 3);
    cyc();

    // zero length on requester 1
    bus.req1 = 1'b1; bus.len1 = 4'd0;
    cyc(); chk("d2_gnt1", int'(bus.gnt1), 1); chk("d2_q", int'(bus.q), 0);
    cyc(); chk("d2_done1", int'(bus.done1), 1);
    bus.req1 = 1'b0;
    cyc(); cyc();

    // random traffic with a mid-run reset
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if (!did_reset && i > 2000 && own >= 0 && !fin && cnt > 0) begin
        did_reset = 1'b1;
        #3 reset = 1'b0;
        #1;
        model_reset();
        chk("mr_q", int'(bus.q), 0);
        chk("mr_gnt", int'({bus.gnt1, bus.gnt0}), 0);
        chk("mr_busy", int'(bus.busy), 0);
        chk("mr_done", int'({bus.done1, bus.done0}), 0);
        #1 reset = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        cyc();
        chk("mr_tie_gnt0", int'(bus.gnt0), 1);
      end
      if (bus.req0 && (e_done0 || $urandom_range(0, 39) == 0)) bus.req0 = 1'b0;
      else if (!bus.req0 && $urandom_range(0, 2) == 0) bus.req0 = 1'b1;
      if (bus.req1 && (e_done1 || $urandom_range(0, 39) == 0)) bus.req1 = 1'b0;
      else if (!bus.req1 && $urandom_range(0, 2) == 0) bus.req1 = 1'b1;
      if ($urandom_range(0, 3) == 0)
        bus.len0 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0)
        bus.len1 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
      bus.tick = ($urandom_range(0, 9) < 7);
    end
    chk("mr_reached", int'(did_reset), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
